// File: rtl/op_fetch_sequencer.sv
// Opcode fetch / T-cycle / interrupt sequencer for the CPU core.
// Optional OP_SEQ_PERF_EN adds a retired-fetch counter (instr_count).
module op_fetch_sequencer #(
  parameter int RESET_CYCLES = 7,
  parameter int T_W          = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cpu_en,
  input  logic           rdy,
  input  logic           exec_done,
  input  logic           nmi_n,
  input  logic           irq_n,
  input  logic           i_flag,
  output logic           op_write,
  output logic           op_force_brk,
  output logic           sync,
  output logic [T_W-1:0] t_cycle,
  output logic [1:0]     int_kind,
  output logic           int_ack,
`ifdef OP_SEQ_PERF_EN
  output logic [31:0]    instr_count,
`endif
  output logic           halted
);

  typedef enum logic [1:0] {
    RST_SEQ = 2'd0,
    FETCH   = 2'd1,
    EXEC    = 2'd2,
    HALT    = 2'd3
  } state_e;

  localparam logic [T_W-1:0] T_MAX  = {T_W{1'b1}};
  localparam logic [T_W-1:0] T_RLST = T_W'(RESET_CYCLES - 1);
  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_IRQ  = 2'b01;
  localparam logic [1:0] K_NMI  = 2'b10;
  localparam logic [1:0] K_RST  = 2'b11;

  state_e         state_q, state_d;
  logic [T_W-1:0] t_q, t_d;
  logic [1:0]     kind_q, kind_d;
  logic           pend_q, pend_d;
  logic           prev_q, prev_d;

  logic       adv;
  logic       take_nmi;
  logic       take_irq;
  logic       nmi_fell;
  logic [1:0] fetch_kind;

  assign adv      = cpu_en & rdy;
  assign take_nmi = pend_q;
  assign take_irq = ~pend_q & ~irq_n & ~i_flag;
  assign nmi_fell = cpu_en & prev_q & ~nmi_n;
  assign t_cycle  = t_q;

  // Next-state, T-counter, interrupt pick and combinational strobes
  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    kind_d       = kind_q;
    pend_d       = pend_q;
    prev_d       = prev_q;
    op_write     = 1'b0;
    op_force_brk = 1'b0;
    sync         = 1'b0;
    int_ack      = 1'b0;
    halted       = 1'b0;
    int_kind     = kind_q;
    fetch_kind   = take_nmi ? K_NMI :
                   take_irq ? K_IRQ : K_NONE;

    // NMI edge detector runs on cpu_en even while the bus is stalled
    if (cpu_en) prev_d = nmi_n;

    unique case (state_q)
      RST_SEQ: begin
        if (adv) begin
          if (t_q == T_RLST) begin
            state_d = FETCH;
            t_d     = '0;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      FETCH: begin
        sync         = 1'b1;
        op_write     = rdy;
        op_force_brk = take_nmi | take_irq;
        int_ack      = (take_nmi | take_irq) & rdy;
        int_kind     = fetch_kind;
        if (adv) begin
          kind_d  = fetch_kind;
          state_d = EXEC;
          t_d     = T_W'(1);
          if (take_nmi) pend_d = 1'b0;
        end
      end
      EXEC: begin
        if (adv) begin
          if (exec_done) begin
            state_d = FETCH;
            t_d     = '0;
          end else if (t_q == T_MAX) begin
            state_d = HALT;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = RST_SEQ;
    endcase

    // A new edge on the consuming cycle keeps the request pending
    if (nmi_fell) pend_d = 1'b1;
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_SEQ;
      t_q     <= '0;
      kind_q  <= K_RST;
      pend_q  <= 1'b0;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      kind_q  <= kind_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
    end
  end

`ifdef OP_SEQ_PERF_EN
  logic [31:0] cnt_q, cnt_d;

  // Count every accepted fetch, injected BRK included
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == FETCH && adv) cnt_d = cnt_q + 32'd1;
  end

  // Fetch counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_op_fetch_sequencer.sv
// Bench for op_fetch_sequencer: directed scenarios, then random
// stimulus, all checked against a behavioural model.
module tb_op_fetch_sequencer;

  localparam int RC   = 7;
  localparam int TMAX = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_en = 1'b1;
  logic       rdy = 1'b1;
  logic       exec_done = 1'b0;
  logic       nmi_n = 1'b1;
  logic       irq_n = 1'b1;
  logic       i_flag = 1'b1;
  logic       op_write, op_force_brk, sync, int_ack, halted;
  logic [2:0] t_cycle;
  logic [1:0] int_kind;
`ifdef OP_SEQ_PERF_EN
  logic [31:0] instr_count;
`endif

  int checks = 0;
  int errors = 0;

  // model: mode 0=reset seq 1=fetch 2=exec 3=halt
  int mode, mt, mkind;
  bit mpend, mprev;
  longint mcnt;

  // expected values of the current cycle
  bit e_sync, e_opw, e_brk, e_ack, e_halt;
  int e_kind;

  op_fetch_sequencer dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .rdy(rdy),
    .exec_done(exec_done), .nmi_n(nmi_n), .irq_n(irq_n),
    .i_flag(i_flag), .op_write(op_write),
    .op_force_brk(op_force_brk), .sync(sync),
    .t_cycle(t_cycle), .int_kind(int_kind), .int_ack(int_ack),
`ifdef OP_SEQ_PERF_EN
    .instr_count(instr_count),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // expected outputs from the model and current inputs
  task automatic expect_now();
    bit tn, ti;
    tn     = (mode == 1) && mpend;
    ti     = (mode == 1) && !mpend && !irq_n && !i_flag;
    e_sync = (mode == 1);
    e_opw  = (mode == 1) && rdy;
    e_brk  = tn || ti;
    e_ack  = e_brk && rdy;
    e_halt = (mode == 3);
    e_kind = (mode == 1) ? (tn ? 2 : ti ? 1 : 0) : mkind;
  endtask

  task automatic model_clock();
    bit fell, adv;
    if (reset) begin
      mode = 0; mt = 0; mkind = 3; mpend = 0; mprev = 1; mcnt = 0;
      return;
    end
    adv  = cpu_en && rdy;
    fell = cpu_en && mprev && !nmi_n;
    if (cpu_en) mprev = nmi_n;
    if (adv) begin
      case (mode)
        0: if (mt == RC - 1) begin mode = 1; mt = 0; end
           else mt++;
        1: begin
          if (mpend) mpend = 0;
          mkind = e_kind;
          mcnt  = (mcnt + 1) % 64'h1_0000_0000;
          mode  = 2; mt = 1;
        end
        2: if (exec_done) begin mode = 1; mt = 0; end
           else if (mt == TMAX) mode = 3;
           else mt++;
        default: ;
      endcase
    end
    if (fell) mpend = 1;
  endtask

  // check this cycle, then advance through one clock edge
  task automatic step();
    #2;
    expect_now();
    if (!reset) begin
      chk("sync", sync, e_sync);
      chk("op_write", op_write, e_opw);
      chk("force_brk", op_force_brk, e_brk);
      chk("int_ack", int_ack, e_ack);
      chk("halted", halted, e_halt);
      chk("int_kind", int_kind, e_kind);
      chk("t_cycle", t_cycle, mt);
`ifdef OP_SEQ_PERF_EN
      chk("instr_count", instr_count, mcnt[31:0]);
`endif
    end
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic run_to_fetch(input bit done_at2);
    int n = 0;
    while (mode != 1 && n < 40) begin
      exec_done = done_at2 ? (mt == 2) : 1'b1;
      step();
      n++;
    end
    chk("reach_fetch", mode, 1);
  endtask

  initial begin
    // reset 3 cycles
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    #2;
    chk("rst_kind", int_kind, 2'b11);
    chk("rst_halted", halted, 1'b0);
    chk("rst_t", t_cycle, 0);
    begin
      int n = 0;
      while (!sync && n < 20) begin step(); n++; end
      chk("first_sync_cycles", n, RC);
    end

    // exec_done at t=2: t goes 0,1,2,0
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 3; i++) begin
        exec_done = (mt == 2);
        #2;
        chk("seq_t", t_cycle, i);
        chk("seq_opw", op_write, i == 0);
        step();
      end
    exec_done = 1'b0;

    // NMI edge in EXEC with IRQ also asserted
    step();
    chk("in_exec", mode, 2);
    nmi_n = 1'b0; irq_n = 1'b0; i_flag = 1'b0;
    run_to_fetch(1);
    #2;
    chk("nmi_brk", op_force_brk, 1);
    chk("nmi_kind", int_kind, 2'b10);
    chk("nmi_ack", int_ack, 1);
    step();
    run_to_fetch(1);
    #2;
    chk("irq_kind", int_kind, 2'b01);
    chk("irq_brk", op_force_brk, 1);
    step();
    nmi_n = 1'b1;

    // IRQ masked
    i_flag = 1'b1;
    run_to_fetch(1);
    #2;
    chk("mask_brk", op_force_brk, 0);
    chk("mask_kind", int_kind, 2'b00);
    irq_n = 1'b1;

    // bus stall during fetch
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("stall_opw", op_write, 0);
      chk("stall_sync", sync, 1);
      step();
    end
    rdy = 1'b1;
    step();
    chk("after_stall_exec", mode, 2);

    // jam: no exec_done through t_max
    exec_done = 1'b0;
    for (int i = 0; i < 9; i++) step();
    #2;
    chk("jam_halted", halted, 1);
    chk("jam_t", t_cycle, TMAX);
    nmi_n = 1'b0;
    irq_n = 1'b0; i_flag = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2;
    chk("jam_stays", halted, 1);
    chk("jam_no_write", op_write, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #2;
    chk("jam_cleared", halted, 0);

    // random phase
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom % 300) == 0;
      cpu_en    = ($urandom % 8) != 0;
      rdy       = ($urandom % 6) != 0;
      exec_done = ($urandom % 3) == 0;
      if (($urandom % 20) == 0) nmi_n = ~nmi_n;
      irq_n     = ($urandom % 4) != 0;
      i_flag    = ($urandom % 2) == 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
